// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the CPU run sequencer.
package cpu_seq_pkg;

  localparam int NUM_REGS       = 32;
  localparam int IDX_W          = 5;
  localparam int DEF_IMEM_DEPTH = 256;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_CYC_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DUMP = 3'd3,
    ST_DONE = 3'd4
  } seq_state_t;

  // Registered control/status flags, one set per state.
  typedef struct packed {
    logic ld_ready;
    logic cpu_rst;
    logic cpu_start;
    logic dump_valid;
    logic busy;
    logic done;
  } seq_flags_t;

  // Flag values that hold for the whole time the FSM sits in state s.
  function automatic seq_flags_t flags_of(input seq_state_t s);
    seq_flags_t f;
    f = 6'b000000;
    case (s)
      ST_IDLE: f.cpu_rst = 1'b1;
      ST_LOAD: begin
        f.ld_ready = 1'b1;
        f.cpu_rst  = 1'b1;
        f.busy     = 1'b1;
      end
      ST_RUN: begin
        f.cpu_start = 1'b1;
        f.busy      = 1'b1;
      end
      ST_DUMP: begin
        f.dump_valid = 1'b1;
        f.busy       = 1'b1;
      end
      ST_DONE: f.done = 1'b1;
      default: f.cpu_rst = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/cpu_run_sequencer_seq_counter.sv
// Saturating up-counter with clear, enable and a terminal-match flag.
// MATCH_NEXT=1 compares the incremented value, so the flag marks the cycle
// whose increment reaches the terminal count; MATCH_NEXT=0 compares the
// current value.
module seq_counter #(
  parameter int W          = 8,
  parameter bit MATCH_NEXT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         hit
);

  logic [W-1:0] inc_s;

  assign inc_s = (count == {W{1'b1}}) ? count : count + {{(W-1){1'b0}}, 1'b1};
  assign hit   = MATCH_NEXT ? (inc_s == term) : (count == term);

  // Count register: reset and clear win over enable; saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (clr) begin
      count <= {W{1'b0}};
    end else if (en) begin
      count <= inc_s;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/cpu_run_sequencer.sv
// Run controller: load program into imem, run the CPU for a bounded number
// of cycles (or until halt), then stream out all architectural registers.
module cpu_run_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CYC_W      = DEF_CYC_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              go_i,
  input  logic [ADDR_W:0]   ld_count_i,
  input  logic [CYC_W-1:0]  max_cycles_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [DATA_W-1:0] imem_wdata_o,
  output logic              cpu_rst_o,
  output logic              cpu_start_o,
  input  logic              halt_i,
  output logic [IDX_W-1:0]  rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [IDX_W-1:0]  dump_idx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CYC_W-1:0]  cycles_o
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(IMEM_DEPTH);

  seq_state_t        state_r;
  seq_flags_t        flags_r;
  logic [ADDR_W-1:0] ld_last_r;
  logic [CYC_W-1:0]  max_r;

  logic [ADDR_W:0]   ld_sat_s;
  logic [ADDR_W-1:0] load_ptr_s;
  logic [IDX_W-1:0]  idx_s;
  logic              go_ok_s;
  logic              accept_s;
  logic              beat_s;
  logic              ld_hit_s;
  logic              cyc_hit_s;
  logic              idx_hit_s;
  seq_state_t        start_state_s;
  seq_state_t        load_exit_s;

  assign ld_sat_s = (ld_count_i > DEPTH_C) ? DEPTH_C : ld_count_i;
  assign go_ok_s  = go_i && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign accept_s = ld_valid_i && flags_r.ld_ready;
  assign beat_s   = flags_r.dump_valid && dump_ready_i;

  // First state after an accepted go: skip LOAD and/or RUN when their counts are zero.
  always_comb begin
    start_state_s = ST_LOAD;
    if (ld_count_i != {(ADDR_W + 1){1'b0}}) begin
      start_state_s = ST_LOAD;
    end else if (max_cycles_i != {CYC_W{1'b0}}) begin
      start_state_s = ST_RUN;
    end else begin
      start_state_s = ST_DUMP;
    end
  end

  // Where LOAD goes after its last word: straight to DUMP for a zero-length run.
  always_comb begin
    load_exit_s = ST_RUN;
    if (max_r == {CYC_W{1'b0}}) begin
      load_exit_s = ST_DUMP;
    end else begin
      load_exit_s = ST_RUN;
    end
  end

  seq_counter #(.W(ADDR_W), .MATCH_NEXT(1'b0)) u_load_ptr (
    .clk   (clk_i),
    .rst   (rst_i),
    .clr   (go_ok_s),
    .en    (accept_s),
    .term  (ld_last_r),
    .count (load_ptr_s),
    .hit   (ld_hit_s)
  );

  seq_counter #(.W(CYC_W), .MATCH_NEXT(1'b1)) u_cycles (
    .clk   (clk_i),
    .rst   (rst_i),
    .clr   (go_ok_s),
    .en    (flags_r.cpu_start),
    .term  (max_r),
    .count (cycles_o),
    .hit   (cyc_hit_s)
  );

  seq_counter #(.W(IDX_W), .MATCH_NEXT(1'b0)) u_dump_idx (
    .clk   (clk_i),
    .rst   (rst_i),
    .clr   (go_ok_s),
    .en    (beat_s),
    .term  (5'd31),
    .count (idx_s),
    .hit   (idx_hit_s)
  );

  // Sequencer FSM: state and all status flags move together on each transition.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      flags_r   <= flags_of(ST_IDLE);
      ld_last_r <= {ADDR_W{1'b0}};
      max_r     <= {CYC_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (go_i) begin
            // Wraps harmlessly for a zero count; LOAD is skipped then.
            ld_last_r <= ADDR_W'(ld_sat_s - {{ADDR_W{1'b0}}, 1'b1});
            max_r     <= max_cycles_i;
            state_r   <= start_state_s;
            flags_r   <= flags_of(start_state_s);
          end
        end
        ST_LOAD: begin
          if (accept_s && ld_hit_s) begin
            state_r <= load_exit_s;
            flags_r <= flags_of(load_exit_s);
          end
        end
        ST_RUN: begin
          if (halt_i || cyc_hit_s) begin
            state_r <= ST_DUMP;
            flags_r <= flags_of(ST_DUMP);
          end
        end
        ST_DUMP: begin
          if (beat_s && idx_hit_s) begin
            state_r <= ST_DONE;
            flags_r <= flags_of(ST_DONE);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          flags_r <= flags_of(ST_IDLE);
        end
      endcase
    end
  end

  assign ld_ready_o   = flags_r.ld_ready;
  assign cpu_rst_o    = flags_r.cpu_rst;
  assign cpu_start_o  = flags_r.cpu_start;
  assign dump_valid_o = flags_r.dump_valid;
  assign busy_o       = flags_r.busy;
  assign done_o       = flags_r.done;

  assign imem_we_o    = accept_s;
  assign imem_addr_o  = load_ptr_s;
  assign imem_wdata_o = ld_data_i;

  assign rf_raddr_o   = idx_s;
  assign dump_idx_o   = idx_s;
  assign dump_data_o  = rf_rdata_i;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed testbench for cpu_run_sequencer with hand-computed expectations.
module tb_cpu_run_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        go_i = 1'b0;
  logic [8:0]  ld_count_i = 9'd0;
  logic [15:0] max_cycles_i = 16'd0;
  logic        ld_valid_i = 1'b0;
  logic        ld_ready_o;
  logic [31:0] ld_data_i = 32'd0;
  logic        imem_we_o;
  logic [7:0]  imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        cpu_rst_o;
  logic        cpu_start_o;
  logic        halt_i = 1'b0;
  logic [4:0]  rf_raddr_o;
  logic [31:0] rf_rdata_i;
  logic        dump_valid_o;
  logic        dump_ready_i = 1'b0;
  logic [31:0] dump_data_o;
  logic [4:0]  dump_idx_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] cycles_o;

  int vec_cnt = 0;
  int err_cnt = 0;
  int we_cnt  = 0;

  logic [31:0] prog [5];

  cpu_run_sequencer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .go_i         (go_i),
    .ld_count_i   (ld_count_i),
    .max_cycles_i (max_cycles_i),
    .ld_valid_i   (ld_valid_i),
    .ld_ready_o   (ld_ready_o),
    .ld_data_i    (ld_data_i),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .cpu_rst_o    (cpu_rst_o),
    .cpu_start_o  (cpu_start_o),
    .halt_i       (halt_i),
    .rf_raddr_o   (rf_raddr_o),
    .rf_rdata_i   (rf_rdata_i),
    .dump_valid_o (dump_valid_o),
    .dump_ready_i (dump_ready_i),
    .dump_data_o  (dump_data_o),
    .dump_idx_o   (dump_idx_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .cycles_o     (cycles_o)
  );

  always #5 clk_i = ~clk_i;

  // Register-file stand-in: register n reads as 0x1000 + n.
  assign rf_rdata_i = 32'h0000_1000 + {27'd0, rf_raddr_o};

  // Count instruction-memory writes seen on clock edges.
  always @(posedge clk_i) begin
    if (imem_we_o) we_cnt <= we_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_go(input logic [8:0] ldc, input logic [15:0] maxc);
    go_i         = 1'b1;
    ld_count_i   = ldc;
    max_cycles_i = maxc;
    tick();
    go_i = 1'b0;
  endtask

  task automatic load_words(input int n);
    for (int i = 0; i < n; i++) begin
      ld_valid_i = 1'b1;
      ld_data_i  = prog[i];
      #1;
      check_val("load_ready", {31'd0, ld_ready_o}, 32'd1);
      check_val("imem_we", {31'd0, imem_we_o}, 32'd1);
      check_val("imem_addr", {24'd0, imem_addr_o}, i);
      check_val("imem_wdata", imem_wdata_o, prog[i]);
      tick();
    end
    ld_valid_i = 1'b0;
  endtask

  // Counts consecutive cpu_start cycles; optional halt pulse and ignored go.
  task automatic run_phase(input int exp_len, input int halt_at, input int go_at);
    int n;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (!cpu_start_o) break;
      n++;
      check_val("run_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
      halt_i = (n == halt_at);
      go_i   = (n == go_at);
      tick();
      halt_i = 1'b0;
      go_i   = 1'b0;
    end
    check_val("run_len", n, exp_len);
  endtask

  task automatic dump_phase(input bit toggle);
    int e;
    int cyc;
    e   = 0;
    cyc = 0;
    for (int k = 0; k < 200 && e < 32; k++) begin
      dump_ready_i = toggle ? ((k % 3) == 0) : 1'b1;
      #1;
      check_val("dump_valid", {31'd0, dump_valid_o}, 32'd1);
      check_val("dump_idx", {27'd0, dump_idx_o}, e);
      check_val("dump_data", dump_data_o, 32'h0000_1000 + e);
      if (dump_ready_i) e++;
      cyc++;
      tick();
    end
    dump_ready_i = 1'b0;
    check_val("dump_beats", e, 32);
    check_val("dump_cycles", cyc, toggle ? 94 : 32);
    check_val("done_high", {31'd0, done_o}, 32'd1);
    check_val("done_busy", {31'd0, busy_o}, 32'd0);
    check_val("done_valid", {31'd0, dump_valid_o}, 32'd0);
    check_val("done_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_cpu_rst"}, {31'd0, cpu_rst_o}, 32'd1);
    check_val({tag, "_start"}, {31'd0, cpu_start_o}, 32'd0);
    check_val({tag, "_ld_ready"}, {31'd0, ld_ready_o}, 32'd0);
    check_val({tag, "_imem_we"}, {31'd0, imem_we_o}, 32'd0);
    check_val({tag, "_dump_valid"}, {31'd0, dump_valid_o}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check_val({tag, "_done"}, {31'd0, done_o}, 32'd0);
    check_val({tag, "_cycles"}, {16'd0, cycles_o}, 32'd0);
    check_val({tag, "_raddr"}, {27'd0, rf_raddr_o}, 32'd0);
  endtask

  initial begin
    int we_before;
    prog[0] = 32'h0000_0020;
    prog[1] = 32'h2008_0005;
    prog[2] = 32'h0108_4020;
    prog[3] = 32'h0000_0000;
    prog[4] = 32'hDEAD_BEEF;

    // Power-on reset.
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    check_reset_outs("reset");

    // Load 4 words, run 10 cycles, continuous dump.
    do_go(9'd4, 16'd10);
    check_val("go_ld_ready", {31'd0, ld_ready_o}, 32'd1);
    check_val("go_busy", {31'd0, busy_o}, 32'd1);
    check_val("go_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    load_words(4);
    run_phase(10, 0, 0);
    check_val("run10_cycles", {16'd0, cycles_o}, 32'd10);
    dump_phase(1'b0);
    check_val("run10_writes", we_cnt, 4);
    check_val("done_cycles_hold", {16'd0, cycles_o}, 32'd10);

    // go from DONE restarts: cycles clear and done drops next cycle; stalled dump.
    do_go(9'd0, 16'd2);
    check_val("restart_done", {31'd0, done_o}, 32'd0);
    check_val("restart_cycles", {16'd0, cycles_o}, 32'd0);
    check_val("restart_start", {31'd0, cpu_start_o}, 32'd1);
    run_phase(2, 0, 0);
    check_val("run2_cycles", {16'd0, cycles_o}, 32'd2);
    dump_phase(1'b1);

    // Halt on RUN cycle 3 of 30; go during RUN is ignored.
    do_go(9'd0, 16'd30);
    ld_count_i = 9'd5;
    run_phase(3, 3, 1);
    check_val("halt_cycles", {16'd0, cycles_o}, 32'd3);
    dump_phase(1'b0);

    // Zero load count and zero run length: straight to DUMP.
    we_before = we_cnt;
    do_go(9'd0, 16'd0);
    #1;
    check_val("zero_dump_valid", {31'd0, dump_valid_o}, 32'd1);
    check_val("zero_start", {31'd0, cpu_start_o}, 32'd0);
    check_val("zero_cycles", {16'd0, cycles_o}, 32'd0);
    dump_phase(1'b0);
    check_val("zero_writes", we_cnt - we_before, 0);

    // Reset after 2 of 5 words aborts the load.
    tick();
    we_before = we_cnt;
    do_go(9'd5, 16'd10);
    load_words(2);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check_reset_outs("abort");
    ld_valid_i = 1'b1;
    #1;
    check_val("abort_no_we", {31'd0, imem_we_o}, 32'd0);
    tick();
    ld_valid_i = 1'b0;
    check_val("abort_writes", we_cnt - we_before, 2);

    // Recovery: one word, one cycle.
    do_go(9'd1, 16'd1);
    load_words(1);
    run_phase(1, 0, 0);
    check_val("rec_cycles", {16'd0, cycles_o}, 32'd1);
    dump_phase(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
